// File: rtl/fp32_mul_normalize.sv
// fp32_mul_normalize: back end of an FP32 multiplier. Takes the raw operands
// and the 48-bit significand product from the upstream multiplier array,
// handles special operands, normalises, denormalises tiny results, rounds to
// nearest-even and packs the result with IEEE exception flags.
// Two-stage valid/ready pipeline: S1 normalises, S2 rounds into the output
// register.
module fp32_mul_normalize #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [47:0] in_product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    // Position of the most significant set bit, expressed as leading zeros.
    // The highest set bit is visited last, so it wins.
    function automatic logic [5:0] count_lz(input logic [47:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (v[i]) n = 6'(47 - i);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic in_fire;
    logic s2_load;

    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // S1 combinational: operand classification and normalisation
    // ------------------------------------------------------------------
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]  exp_a_eff, exp_b_eff;
    logic [5:0]  lz;
    logic [9:0]  e_norm;
    logic [47:0] q_norm;
    logic        sign_in;

    assign exp_a  = in_a[30:23];
    assign exp_b  = in_b[30:23];
    assign frac_a = in_a[22:0];
    assign frac_b = in_b[22:0];

    assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign a_zero = (exp_a == 8'h00) && (frac_a == 23'd0);
    assign b_zero = (exp_b == 8'h00) && (frac_b == 23'd0);

    assign sign_in = in_a[31] ^ in_b[31];

    // Subnormals share the exponent of the smallest normal.
    assign exp_a_eff = (exp_a == 8'h00) ? 8'd1 : exp_a;
    assign exp_b_eff = (exp_b == 8'h00) ? 8'd1 : exp_b;

    assign lz     = count_lz(in_product);
    assign q_norm = in_product << lz;
    // Two's-complement 10-bit exponent; negative values mean a tiny result.
    assign e_norm = {2'b00, exp_a_eff} + {2'b00, exp_b_eff} - 10'd126 - {4'b0000, lz};

    logic        sp_hit;
    logic [31:0] sp_result;
    logic [3:0]  sp_flags;

    // Special-operand decode in priority order.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        sp_hit    = 1'b0;
        sp_result = 32'd0;
        sp_flags  = 4'b0000;
        if (a_nan || b_nan) begin
            sp_hit    = 1'b1;
            sp_result = CANON_NAN;
            sp_flags  = {(a_nan && !frac_a[22]) || (b_nan && !frac_b[22]), 3'b000};
        end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            sp_hit    = 1'b1;
            sp_result = CANON_NAN;
            sp_flags  = 4'b1000;
        end else if (a_inf || b_inf) begin
            sp_hit    = 1'b1;
            sp_result = {sign_in, 8'hFF, 23'd0};
        end else if (in_product == 48'd0) begin
            sp_hit    = 1'b1;
            sp_result = {sign_in, 31'd0};
        end
    end

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic        s1_sign;
    logic        s1_special;
    logic [31:0] s1_sp_result;
    logic [3:0]  s1_sp_flags;
    logic [9:0]  s1_exp;
    logic [47:0] s1_q;

    // S1 occupancy: filled on input transfer, emptied when S2 takes the beat.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S1 payload capture on input transfer.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; they are only observed
        // when s1_valid is set, which is itself reset.
        if (in_fire) begin
            s1_sign      <= sign_in;
            s1_special   <= sp_hit;
            s1_sp_result <= sp_result;
            s1_sp_flags  <= sp_flags;
            s1_exp       <= e_norm;
            s1_q         <= q_norm;
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: denormalise, round, pack
    // ------------------------------------------------------------------
    logic        e_tiny;
    logic [9:0]  den_full;
    logic [4:0]  den_amt;
    logic [47:0] q_den;
    logic        den_sticky;
    logic [9:0]  e_pre;
    logic [22:0] frac_t;
    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [23:0] frac_rnd;
    logic [9:0]  e_post;
    logic        inexact;
    logic        overflow;
    logic [31:0] s2_result;
    logic [3:0]  s2_flags;
    logic        unused_q_msb;

    assign e_tiny   = s1_exp[9] || (s1_exp == 10'd0);
    assign den_full = 10'd1 - s1_exp;
    // Beyond 26 places every significand bit is already below the sticky.
    assign den_amt  = !e_tiny ? 5'd0 :
                      (den_full > 10'd26) ? 5'd26 : den_full[4:0];

    assign q_den      = s1_q >> den_amt;
    assign den_sticky = |(s1_q & ((48'd1 << den_amt) - 48'd1));
    assign e_pre      = e_tiny ? 10'd0 : s1_exp;

    assign frac_t     = q_den[46:24];
    assign guard_bit  = q_den[23];
    assign sticky_bit = (|q_den[22:0]) || den_sticky;
    assign round_up   = guard_bit && (sticky_bit || frac_t[0]);
    assign frac_rnd   = {1'b0, frac_t} + {23'd0, round_up};
    // Fraction carry bumps the exponent; subnormal rounds up to min normal.
    assign e_post     = e_pre + {9'd0, frac_rnd[23]};
    assign inexact    = guard_bit || sticky_bit;
    assign overflow   = (e_post >= 10'd255);

    // The hidden bit is implied by the exponent field.
    assign unused_q_msb = q_den[47];

    // Final result selection for the output register.
    always_comb begin
        s2_result = {s1_sign, e_post[7:0], frac_rnd[22:0]};
        s2_flags  = {1'b0, 1'b0, e_tiny && inexact, inexact};
        if (s1_special) begin
            s2_result = s1_sp_result;
            s2_flags  = s1_sp_flags;
        end else if (overflow) begin
            s2_result = {s1_sign, 8'hFF, 23'd0};
            s2_flags  = 4'b0101;
        end
    end

    // Output register: loads from S1 when empty or draining, holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 4'b0000;
        end else if (s2_load) begin
            s2_valid   <= 1'b1;
            out_result <= s2_result;
            out_flags  <= s2_flags;
        end else if (out_ready) begin
            s2_valid   <= 1'b0;
        end
    end

endmodule
